// File: rtl/aes_mix_pkg.sv
// Shared types and GF(2^8) helpers for the sequential AES MixColumns stage.
// State layout: byte (r,c) sits at packed index 15-4r-c, i.e. bits 127-32r-8c -: 8.
package aes_mix_pkg;

  localparam logic [7:0] POLY = 8'h1B;

  typedef logic [15:0][7:0] state_t;   // 16 bytes, row-major as on the bus
  typedef logic [3:0][7:0]  column_t;  // element r = row r of one column

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } mix_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Pull column c out of a row-major state
  function automatic column_t get_column(input state_t s, input logic [1:0] c);
    column_t col;
    for (int r = 0; r < 4; r++) begin
      col[r] = s[15 - 4*r - int'(c)];
    end
    return col;
  endfunction

  // Return s with column c overwritten by col
  function automatic state_t put_column(input state_t s, input logic [1:0] c,
                                        input column_t col);
    state_t t;
    t = s;
    for (int r = 0; r < 4; r++) begin
      t[15 - 4*r - int'(c)] = col[r];
    end
    return t;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumns on a single 32-bit column.
// The inverse matrix is only built when MIXCOL_INVERSE_EN is defined;
// otherwise inv_i is ignored and the unit is forward-only.
import aes_mix_pkg::*;

module mix_column_unit (
  input  column_t col_i,
  input  logic    inv_i,
  output column_t col_o
);

  column_t fwd_col;
`ifdef MIXCOL_INVERSE_EN
  column_t inv_col;
`endif

  // Each row uses the same coefficient row, rotated by the row number
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    localparam int R1 = (gi + 1) % 4;
    localparam int R2 = (gi + 2) % 4;
    localparam int R3 = (gi + 3) % 4;

    assign fwd_col[gi] = gf_mul2(col_i[gi]) ^ gf_mul3(col_i[R1]) ^
                         col_i[R2] ^ col_i[R3];
`ifdef MIXCOL_INVERSE_EN
    assign inv_col[gi] = gf_mul14(col_i[gi]) ^ gf_mul11(col_i[R1]) ^
                         gf_mul13(col_i[R2]) ^ gf_mul9(col_i[R3]);
`endif
  end

`ifdef MIXCOL_INVERSE_EN
  assign col_o = inv_i ? inv_col : fwd_col;
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign col_o      = fwd_col;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Handshaked, iterative AES MixColumns stage.
// Captures one state, rewrites LANES columns per cycle in place, then holds
// the result on po_out until the consumer accepts it.
// Optional feature: MIXCOL_INVERSE_EN builds the InvMixColumns path and
// honours pi_inverse; without it the stage is forward-only.
import aes_mix_pkg::*;

module mix_columns_seq #(
  parameter int LANES   = 1,
  parameter int OUT_REG = 1
) (
  input  logic         pi_clk,
  input  logic         pi_rst,
  input  logic         pi_valid,
  output logic         po_in_ready,
  input  logic         pi_inverse,
  input  logic [127:0] pi_in,
  output logic         po_valid,
  input  logic         pi_out_ready,
  output logic [127:0] po_out,
  output logic         po_busy
);

  // Only 1, 2 and 4 divide the four columns evenly
  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("mix_columns_seq: LANES must be 1, 2 or 4");
  end

  localparam int         NSTEPS   = 4 / LANES;
  localparam logic [1:0] LAST_CNT = 2'(NSTEPS - 1);

  mix_state_e state_q, state_d;
  logic [1:0] col_cnt_q, col_cnt_d;
  state_t     data_q, data_d;
  logic       inv_q, inv_d;
  state_t     out_q, out_d;

  logic       inv_sel;
  column_t    lane_in  [LANES];
  column_t    lane_out [LANES];
  logic [1:0] lane_idx [LANES];
  state_t     mixed_state;

`ifdef MIXCOL_INVERSE_EN
  assign inv_sel = pi_inverse;
`else
  logic unused_inverse;
  assign unused_inverse = pi_inverse;
  assign inv_sel        = 1'b0;
`endif

  // One column unit per lane, working on columns col_cnt*LANES .. +LANES-1
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_idx[gi] = 2'(int'(col_cnt_q) * LANES + gi);
    assign lane_in[gi]  = get_column(data_q, lane_idx[gi]);

    mix_column_unit u_mix (
      .col_i (lane_in[gi]),
      .inv_i (inv_q),
      .col_o (lane_out[gi])
    );
  end

  // Splice this cycle's transformed columns back into the working state
  always_comb begin
    mixed_state = data_q;
    for (int l = 0; l < LANES; l++) begin
      mixed_state = put_column(mixed_state, lane_idx[l], lane_out[l]);
    end
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    data_d      = data_q;
    inv_d       = inv_q;
    out_d       = out_q;
    po_in_ready = 1'b0;
    po_valid    = 1'b0;
    po_busy     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        po_in_ready = 1'b1;
        if (pi_valid) begin
          data_d    = pi_in;
          inv_d     = inv_sel;
          col_cnt_d = 2'd0;
          state_d   = ST_BUSY;
        end
      end

      ST_BUSY: begin
        po_busy   = 1'b1;
        data_d    = mixed_state;
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == LAST_CNT) begin
          col_cnt_d = 2'd0;
          if (OUT_REG != 0) begin
            state_d = ST_FLUSH;
          end else begin
            // No output stage: publish the finished state straight away
            out_d   = mixed_state;
            state_d = ST_DONE;
          end
        end
      end

      ST_FLUSH: begin
        po_busy = 1'b1;
        out_d   = data_q;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        po_valid = 1'b1;
        if (pi_out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight block
  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= 2'd0;
      data_q    <= '0;
      inv_q     <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      data_q    <= data_d;
      inv_q     <= inv_d;
      out_q     <= out_d;
    end
  end

  assign po_out = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: six instances covering LANES 1/2/4 with and
// without the output register, directed vectors plus a randomised
// back-to-back run on the LANES=1 / OUT_REG=1 instance.
module tb_mix_columns_seq;

`ifdef MIXCOL_INVERSE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam int NINST = 6;

  localparam logic [127:0] V1_IN  = 128'hdbf201c6_130a01c6_532201c6_455c01c6;
  localparam logic [127:0] V1_OUT = 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6;
  localparam logic [127:0] V3_IN  = 128'hd42d01c6_d42601c6_d43101c6_d54c01c6;
  localparam logic [127:0] V3_OUT = 128'hd54d01c6_d57e01c6_d7bd01c6_d6f801c6;

  logic         pi_clk = 1'b0;
  logic         pi_rst;
  logic         pi_inverse;
  logic [127:0] pi_in;
  logic         valid_v [NINST];
  logic         ordy_v  [NINST];
  logic         ir_v    [NINST];
  logic         ov_v    [NINST];
  logic         busy_v  [NINST];
  logic [127:0] out_v   [NINST];

  int n_vec = 0;
  int n_err = 0;

  always #5 pi_clk = ~pi_clk;

  for (genvar gi = 0; gi < NINST; gi++) begin : g_dut
    localparam int L = (gi % 3 == 0) ? 1 : ((gi % 3 == 1) ? 2 : 4);
    localparam int O = (gi < 3) ? 1 : 0;
    mix_columns_seq #(.LANES(L), .OUT_REG(O)) dut (
      .pi_clk       (pi_clk),
      .pi_rst       (pi_rst),
      .pi_valid     (valid_v[gi]),
      .po_in_ready  (ir_v[gi]),
      .pi_inverse   (pi_inverse),
      .pi_in        (pi_in),
      .po_valid     (ov_v[gi]),
      .pi_out_ready (ordy_v[gi]),
      .po_out       (out_v[gi]),
      .po_busy      (busy_v[gi])
    );
  end

  function automatic int lanes_of(input int idx);
    return (idx % 3 == 0) ? 1 : ((idx % 3 == 1) ? 2 : 4);
  endfunction

  function automatic int latency_of(input int idx);
    return 4 / lanes_of(idx) + ((idx < 3) ? 1 : 0);
  endfunction

  // Shift-and-add GF(2^8) multiply, independent of the xtime chain
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic       hi;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
    end
    return p;
  endfunction

  // Reference MixColumns / InvMixColumns on the row-major bus layout
  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
    logic [7:0]   cf [4];
    logic [127:0] o;
    logic [7:0]   acc;
    if (inv) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(cf[(k - r + 4) % 4], s[127 - 32*k - 8*c -: 8]);
        end
        o[127 - 32*r - 8*c -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one state to instance idx, then measure latency and result
  task automatic send_block(input int idx, input logic [127:0] data, input logic inv,
                            input logic [127:0] exp_out, input string tag);
    int lat;
    check($sformatf("%s_rdy", tag), 128'(ir_v[idx]), 128'(1));
    pi_in        = data;
    pi_inverse   = inv;
    valid_v[idx] = 1'b1;
    @(posedge pi_clk); #1;
    valid_v[idx] = 1'b0;
    check($sformatf("%s_busy", tag), 128'(busy_v[idx]), 128'(1));
    lat = 0;
    while (!ov_v[idx] && lat < 40) begin
      @(posedge pi_clk); #1;
      lat++;
    end
    check($sformatf("%s_lat", tag), 128'(lat), 128'(latency_of(idx)));
    check($sformatf("%s_out", tag), out_v[idx], exp_out);
    $display("blk %s inst%0d in=%h out=%h lat=%0d", tag, idx, data, out_v[idx], lat);
  endtask

  // Consumer takes the result; the stage must be idle on the next cycle
  task automatic release_block(input int idx, input string tag);
    ordy_v[idx] = 1'b1;
    @(posedge pi_clk); #1;
    ordy_v[idx] = 1'b0;
    check($sformatf("%s_vld_lo", tag), 128'(ov_v[idx]), 128'(0));
    check($sformatf("%s_rdy_hi", tag), 128'(ir_v[idx]), 128'(1));
  endtask

  initial begin
    logic [127:0] exp_q [$];
    logic [127:0] cur, held, obs, exp_v;
    logic         cur_inv, acc, take;
    int           sent, got, cyc;

    pi_rst     = 1'b1;
    pi_inverse = 1'b0;
    pi_in      = '0;
    for (int i = 0; i < NINST; i++) begin
      valid_v[i] = 1'b0;
      ordy_v[i]  = 1'b0;
    end
    repeat (3) @(posedge pi_clk);
    #1;
    pi_rst = 1'b0;

    // Reset state
    check("rst_vld",  128'(ov_v[0]),   128'(0));
    check("rst_out",  out_v[0],        128'(0));
    check("rst_rdy",  128'(ir_v[0]),   128'(1));
    check("rst_busy", 128'(busy_v[0]), 128'(0));

    // Forward vector on every LANES / OUT_REG combination
    for (int i = 0; i < NINST; i++) begin
      send_block(i, V1_IN, 1'b0, V1_OUT, $sformatf("fwd%0d", i));
      release_block(i, $sformatf("fwd%0d", i));
    end

    // Inverse request: honoured only when the inverse path is built
    exp_v = INV_EN ? V1_IN : mix_ref(V1_OUT, 1'b0);
    send_block(0, V1_OUT, 1'b1, exp_v, "inv");
    release_block(0, "inv");

    // Backpressure: result held, new inputs ignored while waiting
    send_block(0, V3_IN, 1'b0, V3_OUT, "bp");
    held = out_v[0];
    for (int k = 0; k < 10; k++) begin
      valid_v[0] = k[0];
      pi_in      = 128'hffff_0000_1234_5678_9abc_def0_0f0f_a5a5 ^ 128'(k);
      @(posedge pi_clk); #1;
      check($sformatf("bp_hold%0d", k), out_v[0], held);
      check($sformatf("bp_vld%0d", k), 128'(ov_v[0]), 128'(1));
      check($sformatf("bp_rdy%0d", k), 128'(ir_v[0]), 128'(0));
    end
    valid_v[0] = 1'b0;
    release_block(0, "bp");
    send_block(0, V1_IN, 1'b0, V1_OUT, "bp_next");
    release_block(0, "bp_next");

    // Reset in the middle of BUSY (third column about to be processed)
    pi_in      = V3_IN;
    pi_inverse = 1'b0;
    valid_v[0] = 1'b1;
    @(posedge pi_clk); #1;
    valid_v[0] = 1'b0;
    repeat (2) begin
      @(posedge pi_clk); #1;
    end
    pi_rst = 1'b1;
    @(posedge pi_clk); #1;
    pi_rst = 1'b0;
    check("mrst_vld",  128'(ov_v[0]),   128'(0));
    check("mrst_out",  out_v[0],        128'(0));
    check("mrst_rdy",  128'(ir_v[0]),   128'(1));
    check("mrst_busy", 128'(busy_v[0]), 128'(0));
    send_block(0, V3_IN, 1'b0, V3_OUT, "mrst_new");
    release_block(0, "mrst_new");

    // Back-to-back random traffic against the reference model
    sent = 0;
    got  = 0;
    cyc  = 0;
    cur  = '0;
    cur_inv = 1'b0;
    while ((sent < 100 || got < sent) && cyc < 20000) begin
      if (!valid_v[0] && sent < 100 && $urandom_range(0, 3) != 0) begin
        cur        = {$urandom, $urandom, $urandom, $urandom};
        cur_inv    = 1'($urandom_range(0, 1));
        pi_in      = cur;
        pi_inverse = cur_inv;
        valid_v[0] = 1'b1;
      end
      ordy_v[0] = ($urandom_range(0, 2) != 0);
      acc  = valid_v[0] && ir_v[0];
      take = ov_v[0] && ordy_v[0];
      obs  = out_v[0];
      @(posedge pi_clk); #1;
      cyc++;
      if (acc) begin
        exp_q.push_back(mix_ref(cur, cur_inv && INV_EN));
        sent++;
        valid_v[0] = 1'b0;
      end
      if (take) begin
        if (exp_q.size() == 0) begin
          check("b2b_extra", 128'(exp_q.size()), 128'(1));
        end else begin
          exp_v = exp_q.pop_front();
          check($sformatf("b2b%0d", got), obs, exp_v);
          $display("b2b %0d out=%h", got, obs);
        end
        got++;
      end
    end
    ordy_v[0]  = 1'b0;
    valid_v[0] = 1'b0;
    check("b2b_sent", 128'(sent), 128'(100));
    check("b2b_got",  128'(got),  128'(100));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
